// File: rtl/universal_shift_register.sv
// N-bit universal shift register (shift/rotate/load/hold) with a burst sequencer.
// Ports: clk, rst, clkenb, modo, dir, s_in_izq, s_in_der, d, start, count,
//        q, s_out_der, s_out_izq, busy, done.
module universal_shift_register #(
   parameter int N  = 4,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clkenb,
   input  logic [1:0]    modo,
   input  logic          dir,
   input  logic          s_in_izq,
   input  logic          s_in_der,
   input  logic [N-1:0]  d,
   input  logic          start,
   input  logic [CW-1:0] count,
   output logic [N-1:0]  q,
   output logic          s_out_der,
   output logic          s_out_izq,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   rem, rem_n;
   logic [1:0]      lmode;
   logic            ldir;
   logic [1:0]      op_mode;
   logic            op_dir;
   logic [N-1:0]    q_op;
   logic            do_op;
   logic            latch;

   assign s_out_der = q[0];
   assign s_out_izq = q[N-1];

   // In RUN the frozen op is used; otherwise the live inputs.
   always_comb begin
      op_mode = modo;
      op_dir  = dir;
      if (state == RUN) begin
         op_mode = lmode;
         op_dir  = ldir;
      end
      case (op_mode)
         2'b00:   q_op = op_dir ? {q[N-2:0], s_in_der}
                                : {s_in_izq, q[N-1:1]};
         2'b01:   q_op = op_dir ? {q[N-2:0], q[N-1]}
                                : {q[0], q[N-1:1]};
         2'b10:   q_op = d;
         default: q_op = q;
      endcase
   end

   always_comb begin
      state_n = state;
      rem_n   = rem;
      do_op   = 1'b0;
      latch   = 1'b0;
      unique case (state)
         IDLE: begin
            if (clkenb) begin
               if (start) begin
                  if (count == '0) begin
                     state_n = DONE;
                  end else begin
                     // first op of the burst runs on the start edge
                     do_op   = 1'b1;
                     latch   = 1'b1;
                     rem_n   = count - CW'(1);
                     state_n = (count == CW'(1)) ? DONE : RUN;
                  end
               end else begin
                  do_op = 1'b1;
               end
            end
         end
         RUN: begin
            if (clkenb) begin
               do_op = 1'b1;
               rem_n = rem - CW'(1);
               if (rem == CW'(1)) state_n = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         rem   <= '0;
         lmode <= 2'b11;
         ldir  <= 1'b0;
         q     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         rem   <= rem_n;
         busy  <= (state_n == RUN);
         done  <= (state_n == DONE);
         if (latch) begin
            lmode <= modo;
            ldir  <= dir;
         end
         if (do_op) q <= q_op;
      end
   end

endmodule
